imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 103 ++++++++++
 tb/tb_imem_loader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams words from a valid/ready producer into a 1024x10 instruction memory; optional IMEM_LOADER_CHECKSUM_EN adds a session checksum output
module imem_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  base_addr,
  input  logic [10:0] word_count,
  input  logic        in_valid,
  input  logic [9:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic [9:0]  wr_data,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        wrapped
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,output logic [9:0] checksum
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state_q, state_d;
  logic [9:0] addr_q, addr_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, sum_q, sum_d;
  logic [10:0] rem_q, rem_d;
  logic in_ready_q, in_ready_d, wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d, wrapped_q, wrapped_d;
  logic hs;
  assign hs = in_ready_q & in_valid;
  // Next-state and registered-output computation; outputs derive from the next state so they line up with it
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    wrapped_d = wrapped_q;
    sum_d = sum_q;
    wr_en_d = hs;
    wr_addr_d = hs ? addr_q : wr_addr_q;
    wr_data_d = hs ? in_data : wr_data_q;
    case (state_q)
      IDLE: if (start) begin
        addr_d = base_addr;
        rem_d = word_count;
        wrapped_d = 1'b0;
        sum_d = '0;
        state_d = (word_count == 11'd0) ? DONE : LOAD;
      end
      LOAD: if (hs) begin
        addr_d = addr_q + 10'd1;
        rem_d = rem_q - 11'd1;
        sum_d = sum_q + in_data;
        wrapped_d = wrapped_q | (addr_q == 10'd1023);
        state_d = (rem_q == 11'd1) ? DONE : LOAD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == LOAD;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  // FSM and output registers; reset wins over everything, including a pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      sum_q <= '0;
      wrapped_q <= 1'b0;
      in_ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      sum_q <= sum_d;
      wrapped_q <= wrapped_d;
      in_ready_q <= in_ready_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign in_ready = in_ready_q;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy = busy_q;
  assign cpu_hold = busy_q;
  assign done = done_q;
  assign wrapped = wrapped_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign checksum = sum_q;
`else
  logic unused_sum;
  assign unused_sum = ^sum_q;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench; driver queues expected writes, monitor checks every wr_en
module tb_imem_loader;
  logic clk = 1'b0, reset, start, in_valid;
  logic [9:0] base_addr, in_data;
  logic [10:0] word_count;
  logic in_ready, wr_en, busy, cpu_hold, done, wrapped;
  logic [9:0] wr_addr, wr_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [9:0] checksum;
`endif
  int checks = 0, errors = 0, done_cnt = 0;
  logic [19:0] exp_q[$];
  logic [9:0] words[$];
  bit vpat[$];

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .cpu_hold(cpu_hold),
    .done(done), .wrapped(wrapped)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: every write must match the oldest queued expectation
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e[19:10]);
        chk("wr_data", wr_data, e[9:0]);
      end
    end
  end

  task automatic check_idle(input string nm);
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_wr_en"}, wr_en, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_cpu_hold"}, cpu_hold, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  // called at posedge+1 with the DUT in IDLE; returns at posedge+1 with the DUT back in IDLE
  task automatic run(input logic [9:0] base, input logic [10:0] cnt, input bit poke, input logic exp_wrap);
    int idx = 0, cyc = 0, d0;
    logic [9:0] a, sum;
    a = base;
    sum = '0;
    d0 = done_cnt;
    start = 1; base_addr = base; word_count = cnt;
    @(posedge clk); #1;
    start = 0; base_addr = 0; word_count = 0;
    while (idx < words.size() && cyc < 100) begin
      in_valid = (cyc < vpat.size()) ? vpat[cyc] : 1'b1;
      in_data = words[idx];
      if (poke) begin
        start = (cyc == 1); base_addr = 10'd7; word_count = 11'd9;
      end
      @(negedge clk);
      chk("busy_in_load", busy, 1);
      chk("hold_in_load", cpu_hold, 1);
      if (in_valid && in_ready) begin
        exp_q.push_back({a, words[idx]});
        sum += words[idx];
        a++;
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0; start = 0;
    chk("load_timeout", cyc < 100, 1);
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 1);
    chk("wr_with_done", wr_en, cnt != 0);
    chk("wrapped", wrapped, exp_wrap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("checksum", checksum, sum);
`endif
    @(posedge clk); #1;
    chk("done_once", done_cnt - d0, 1);
    chk("all_writes_seen", exp_q.size(), 0);
    check_idle("after_done");
  endtask

  initial begin
    reset = 1; start = 0; base_addr = 0; word_count = 0; in_valid = 0; in_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_wrapped", wrapped, 0);
    reset = 0;
    @(posedge clk); #1;
    // three words, continuous; checksum is 0x306
    words = {10'h370, 10'h36D, 10'h029}; vpat = {};
    run(10'd0, 11'd3, 0, 1'b0);
    // wrap across 1023 -> 0, started back-to-back with the previous session
    words = {10'd1, 10'd2, 10'd3, 10'd4};
    run(10'd1022, 11'd4, 0, 1'b1);
    // valid gaps; new start clears wrapped
    words = {10'h155, 10'h2AA}; vpat = {1, 0, 0, 1};
    run(10'd100, 11'd2, 0, 1'b0);
    // zero-length session
    words = {}; vpat = {};
    run(10'd50, 11'd0, 0, 1'b0);
    // start pulsed mid-load must be ignored
    words = {10'h0F0, 10'h00F, 10'h3FF}; vpat = {};
    run(10'd200, 11'd3, 1, 1'b0);
    // reset after the first of three words
    start = 1; base_addr = 10'h40; word_count = 11'd3;
    @(posedge clk); #1;
    start = 0; in_valid = 1; in_data = 10'h111;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    exp_q.push_back({10'h40, 10'h111});
    @(posedge clk); #1;
    in_valid = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check_idle("mid_reset");
    chk("mid_reset_wr_addr", wr_addr, 0);
    chk("mid_reset_wr_data", wr_data, 0);
    chk("mid_reset_queue", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    words = {10'h21F};
    run(10'd5, 11'd1, 0, 1'b0);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
